// File: rtl/eth_firewall.sv
`default_nettype none
// ============================================================================
// Module   : eth_firewall
// Purpose  : RMII receive-path filter. Strips the 14-byte Ethernet header
//            from a bit-ordered dibit stream and forwards payload + FCS only
//            for frames addressed to this board (or broadcast), optionally
//            also requiring a matching EtherType. Emits one-cycle
//            accept/drop status pulses.
// Revision : 1.0 - initial release
// ============================================================================
module eth_firewall #(
  parameter logic [47:0] MAC_ADDR     = 48'h69_69_5A_06_54_91,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter bit          CHECK_ETYPE  = 1'b0,
  parameter logic [15:0] ETYPE        = 16'h0800
) (
  input  logic       clk,
  input  logic       rst,       // asynchronous, active-low
  input  logic       axiiv,
  input  logic [1:0] axiid,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       accept_p,
  output logic       drop_p
);

  // Header layout in dibits: dst MAC 0..23, src MAC 24..47, EtherType 48..55.
  localparam logic [5:0] c_dst_end  = 6'd24;
  localparam logic [5:0] c_et_first = 6'd48;
  localparam logic [5:0] c_hdr_last = 6'd55;
  localparam logic [5:0] c_cnt_max  = 6'd56;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_PASS = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic        r_uc_ok;
  logic        r_bc_ok;
  logic        r_et_ok;

  logic [47:0] w_mac_sh;
  logic [15:0] w_et_sh;
  logic [5:0]  w_et_idx;
  logic        w_in_dst;
  logic        w_in_et;
  logic        w_uc_nxt;
  logic        w_bc_nxt;
  logic        w_et_nxt;
  logic        w_pass;

  // Shift the reference fields so the dibit expected at the current index
  // always sits in the top two bits; out-of-range shifts harmlessly give 0.
  assign w_et_idx = r_cnt - c_et_first;
  assign w_mac_sh = MAC_ADDR << {r_cnt, 1'b0};
  assign w_et_sh  = ETYPE << {w_et_idx, 1'b0};

  assign w_in_dst = (r_cnt < c_dst_end);
  assign w_in_et  = (r_cnt >= c_et_first) && (r_cnt <= c_hdr_last);

  // Flag values including the dibit being sampled now, so the decision at
  // index 55 sees the final EtherType dibit.
  assign w_uc_nxt = r_uc_ok & ~(w_in_dst & (axiid != w_mac_sh[47:46]));
  assign w_bc_nxt = r_bc_ok & ~(w_in_dst & (axiid != 2'b11));
  assign w_et_nxt = r_et_ok & ~(w_in_et  & (axiid != w_et_sh[15:14]));

  assign w_pass = (w_uc_nxt | (ACCEPT_BCAST & w_bc_nxt)) &
                  (~CHECK_ETYPE | w_et_nxt);

  // Header parser, accept/drop FSM and registered forwarding path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_HDR;
      r_cnt    <= 6'd0;
      r_uc_ok  <= 1'b1;
      r_bc_ok  <= 1'b1;
      r_et_ok  <= 1'b1;
      axiov    <= 1'b0;
      axiod    <= 2'b00;
      accept_p <= 1'b0;
      drop_p   <= 1'b0;
    end else begin
      axiov    <= 1'b0;
      axiod    <= 2'b00;
      accept_p <= 1'b0;
      drop_p   <= 1'b0;
      if (!axiiv) begin
        // Any idle cycle ends the frame, whatever state we were in.
        r_state <= S_HDR;
        r_cnt   <= 6'd0;
        r_uc_ok <= 1'b1;
        r_bc_ok <= 1'b1;
        r_et_ok <= 1'b1;
      end else begin
        if (r_cnt != c_cnt_max) begin
          r_cnt <= r_cnt + 6'd1;
        end
        case (r_state)
          S_HDR: begin
            r_uc_ok <= w_uc_nxt;
            r_bc_ok <= w_bc_nxt;
            r_et_ok <= w_et_nxt;
            if (r_cnt == c_hdr_last) begin
              if (w_pass) begin
                r_state  <= S_PASS;
                accept_p <= 1'b1;
              end else begin
                r_state <= S_DROP;
                drop_p  <= 1'b1;
              end
            end
          end
          S_PASS: begin
            axiov <= 1'b1;
            axiod <= axiid;
          end
          S_DROP: begin
            // Swallow the rest of the frame.
          end
          default: begin
            r_state <= S_HDR;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_firewall.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_firewall
// Purpose  : Self-checking bench for eth_firewall. Three instances share one
//            stimulus stream: default parameters, broadcast disabled, and
//            EtherType checking enabled. Expected output dibits and pulses
//            are queued (tagged with their due cycle) as stimulus is driven.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_firewall;

  localparam logic [47:0] c_mac   = 48'h69_69_5A_06_54_91;
  localparam logic [47:0] c_bcast = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [15:0] c_ip    = 16'h0800;
  localparam logic [15:0] c_arp   = 16'h0806;
  localparam int          c_ninst = 3;

  typedef struct {
    int         inst;
    int         cyc;
    logic [1:0] d;
  } dexp_t;

  typedef struct {
    int inst;
    int cyc;
    bit acc;
  } pexp_t;

  logic       clk;
  logic       rst;
  logic       axiiv;
  logic [1:0] axiid;
  logic [2:0] axiov_v;
  logic [1:0] axiod_v [c_ninst];
  logic [2:0] accept_v;
  logic [2:0] drop_v;

  int    checks;
  int    errors;
  int    cyc;
  dexp_t dq[$];
  pexp_t pq[$];

  eth_firewall u_dut_def (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
    .axiov(axiov_v[0]), .axiod(axiod_v[0]),
    .accept_p(accept_v[0]), .drop_p(drop_v[0])
  );

  eth_firewall #(.ACCEPT_BCAST(1'b0)) u_dut_nobc (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
    .axiov(axiov_v[1]), .axiod(axiod_v[1]),
    .accept_p(accept_v[1]), .drop_p(drop_v[1])
  );

  eth_firewall #(.CHECK_ETYPE(1'b1), .ETYPE(16'h0800)) u_dut_et (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
    .axiov(axiov_v[2]), .axiod(axiod_v[2]),
    .accept_p(accept_v[2]), .drop_p(drop_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference decision, written from the frame fields rather than dibit flags.
  function automatic bit model_acc(input int inst, input logic [47:0] dst, input logic [15:0] et);
    bit bc_en;
    bit et_chk;
    bc_en  = (inst != 1);
    et_chk = (inst == 2);
    return ((dst == c_mac) || (bc_en && (dst == c_bcast))) && (!et_chk || (et == c_ip));
  endfunction

  // Drive one frame of len dibits followed by gap idle cycles. When rst_at is
  // non-negative, reset is pulsed asynchronously mid-frame at that dibit.
  task automatic drive_frame(input logic [47:0] dst, input logic [15:0] et, input int len,
                             input bit alt, input int gap, input int rst_at);
    logic [111:0] hdr;
    logic [1:0]   d;
    bit           acc [c_ninst];
    bit           live;
    hdr  = {dst, 32'($urandom), 16'($urandom), et};
    live = 1'b1;
    for (int n = 0; n < c_ninst; n++) acc[n] = model_acc(n, dst, et);
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      if (rst_at >= 0 && i == rst_at + 2) rst = 1'b1;
      if (i < 56)   d = hdr[111 - 2*i -: 2];
      else if (alt) d = ((i - 56) % 2 == 0) ? 2'b01 : 2'b10;
      else          d = 2'($urandom_range(0, 3));
      axiiv = 1'b1;
      axiid = d;
      if (live) begin
        for (int n = 0; n < c_ninst; n++) begin
          if (i == 55)          pq.push_back('{inst: n, cyc: cyc + 1, acc: acc[n]});
          if (i >= 56 && acc[n]) dq.push_back('{inst: n, cyc: cyc + 1, d: d});
        end
      end
      if (i == rst_at) begin
        #2;
        rst = 1'b0;
        #1;
        for (int n = 0; n < c_ninst; n++) check($sformatf("rst_axiov%0d", n), 64'(axiov_v[n]), 64'd0);
        dq.delete();
        pq.delete();
        live = 1'b0;
      end
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
      axiiv = 1'b0;
      axiid = 2'($urandom_range(0, 3));
    end
  endtask

  // Output monitor: every forwarded dibit and every pulse must match the
  // oldest pending expectation for that instance, at its due cycle.
  int    mon_j;
  bit    mon_found;
  dexp_t mon_d;
  pexp_t mon_p;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      for (int i = 0; i < c_ninst; i++) begin
        if (axiov_v[i]) begin
          mon_found = 1'b0;
          for (mon_j = 0; mon_j < dq.size(); mon_j++) begin
            if (dq[mon_j].inst == i) begin
              mon_d = dq[mon_j];
              dq.delete(mon_j);
              mon_found = 1'b1;
              break;
            end
          end
          if (!mon_found) begin
            check($sformatf("unexp_axiov%0d", i), 64'd1, 64'd0);
          end else begin
            check($sformatf("axiod%0d", i), 64'(axiod_v[i]), 64'(mon_d.d));
            check($sformatf("axiod_cyc%0d", i), 64'(cyc), 64'(mon_d.cyc));
          end
        end else begin
          check($sformatf("axiod_idle%0d", i), 64'(axiod_v[i]), 64'd0);
        end
        if (accept_v[i] || drop_v[i]) begin
          check($sformatf("pulse_excl%0d", i), 64'(accept_v[i] & drop_v[i]), 64'd0);
          mon_found = 1'b0;
          for (mon_j = 0; mon_j < pq.size(); mon_j++) begin
            if (pq[mon_j].inst == i) begin
              mon_p = pq[mon_j];
              pq.delete(mon_j);
              mon_found = 1'b1;
              break;
            end
          end
          if (!mon_found) begin
            check($sformatf("unexp_pulse%0d", i), 64'd1, 64'd0);
          end else begin
            check($sformatf("accept_p%0d", i), 64'(accept_v[i]), 64'(mon_p.acc));
            check($sformatf("drop_p%0d", i), 64'(drop_v[i]), 64'(!mon_p.acc));
            check($sformatf("pulse_cyc%0d", i), 64'(cyc), 64'(mon_p.cyc));
          end
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst    = 1'b0;
    axiiv  = 1'b0;
    axiid  = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int n = 0; n < c_ninst; n++) begin
      check($sformatf("reset_axiov%0d", n), 64'(axiov_v[n]), 64'd0);
      check($sformatf("reset_axiod%0d", n), 64'(axiod_v[n]), 64'd0);
      check($sformatf("reset_accept%0d", n), 64'(accept_v[n]), 64'd0);
      check($sformatf("reset_drop%0d", n), 64'(drop_v[n]), 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Unicast, IPv4, 40 alternating payload dibits.
    drive_frame(c_mac, c_ip, 96, 1'b1, 3, -1);
    // Broadcast: accepted except where broadcast is disabled.
    drive_frame(c_bcast, c_ip, 80, 1'b0, 2, -1);
    // Destination off by the last dibit, then a good frame after one idle.
    drive_frame(c_mac ^ 48'h1, c_ip, 70, 1'b0, 1, -1);
    drive_frame(c_mac, c_ip, 72, 1'b0, 2, -1);
    // ARP EtherType: dropped only where EtherType is checked.
    drive_frame(c_mac, c_arp, 75, 1'b0, 1, -1);
    // Header-only frame: decision pulse, no forwarded data.
    drive_frame(c_mac, c_ip, 56, 1'b0, 1, -1);
    // Runt, then a good frame after one idle cycle.
    drive_frame(c_mac, c_ip, 30, 1'b0, 1, -1);
    drive_frame(c_mac, c_ip, 64, 1'b0, 2, -1);
    // Reset mid-payload; the remaining 18 dibits become a runt header.
    drive_frame(c_mac, c_ip, 86, 1'b0, 1, 66);
    drive_frame(c_mac, c_ip, 66, 1'b0, 5, -1);

    check("dq_empty", 64'(dq.size()), 64'd0);
    check("pq_empty", 64'(pq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eth_firewall.md
Name: eth_firewall

Overview:
- Receive-path filter sitting directly upstream of the 32-bit word aggregator.
- Takes the de-preambled, bit-ordered RMII dibit stream (MSB-first within each byte) and strips the 14-byte Ethernet header.
- Forwards payload + FCS dibits only for frames addressed to this board's MAC or to broadcast, optionally also requiring a matching EtherType.
- Rejected frames produce no output; a one-cycle status pulse reports the accept/drop decision.

Parameters:
- MAC_ADDR, 48'h69_69_5A_06_54_91, this board's unicast MAC (bit 47 = first bit on wire after bit-ordering).
- ACCEPT_BCAST, 1, 1 = also accept destination FF:FF:FF:FF:FF:FF.
- CHECK_ETYPE, 0, 1 = additionally require EtherType == ETYPE.
- ETYPE, 16'h0800, required EtherType when CHECK_ETYPE = 1.

Ports:
- clk  input  1  system clock (50 MHz RMII domain)
- rst  input  1  asynchronous, active-low reset
- axiiv  input  1  input dibit valid; high for the whole frame, low between frames
- axiid  input  2  input dibit, MSB-first per byte
- axiov  output  1  output dibit valid
- axiod  output  2  output dibit (payload/FCS only)
- accept_p  output  1  one-cycle pulse: frame accepted
- drop_p  output  1  one-cycle pulse: frame dropped

Behaviour:
- Reset (rst low, async): state = HDR, counter = 0, match flags = 1, axiov/axiod/accept_p/drop_p = 0. Same values while rst is held low.
- Frame = maximal run of cycles with axiiv = 1. Any cycle with axiiv = 0 ends the frame and returns to HDR with counter cleared and flags set, whatever the current state.
- Header indexing: dibit index k counts axiiv = 1 cycles from 0.
  - k = 0..23: destination MAC. Dibit k compared against MAC_ADDR[47-2k -: 2] and against 2'b11.
  - Flags: uc_ok clears on a unicast mismatch; bc_ok clears on a broadcast mismatch.
  - k = 24..47: source MAC, ignored.
  - k = 48..55: EtherType. Compared against ETYPE[15-2(k-48) -: 2]; et_ok clears on mismatch.
- Counter is 6 bits, saturating; it does not advance past 56.
- Decision is taken in the cycle dibit k = 55 is sampled:
  - pass = (uc_ok | (ACCEPT_BCAST & bc_ok)) & (~CHECK_ETYPE | et_ok), using flags updated with dibit 55.
  - pass = 1: next state PASS, accept_p = 1 for the following cycle.
  - pass = 0: next state DROP, drop_p = 1 for the following cycle.
- Frame ending in HDR (fewer than 56 dibits): no output, no pulse.
- PASS: each input dibit with axiiv = 1 is registered, so axiov = 1 and axiod = that dibit exactly one cycle later. Latency 1, no bubbles, no throttling.
- Frame end from PASS: axiov = 0 in the cycle after axiiv is low; axiod = 0 whenever axiov = 0.
- DROP: axiov stays 0 until the frame ends.
- No header dibit is ever forwarded.
- Back-to-back frames separated by a single idle cycle must be handled.
- Pulses: accept_p and drop_p are never high together, and each pulses at most once per frame.
- Registers: state (HDR/PASS/DROP), 6-bit counter, 3 flags, output registers. No RAM or FIFO.

Test Plan:
- Frame to MAC_ADDR, EtherType 0x0800, followed by 40 payload dibits alternating 2'b01/2'b10 -> accept_p pulses once, cycle after dibit 55. Exactly 40 axiov cycles with identical dibits, each delayed 1 cycle. axiov falls 1 cycle after axiiv.
- Broadcast destination with ACCEPT_BCAST = 1 -> payload forwarded. Same frame with ACCEPT_BCAST = 0 -> drop_p pulse, axiov never high.
- Destination differing only in the last dibit (k = 23) -> drop_p pulse, zero output cycles. Next frame (after 1 idle cycle) to MAC_ADDR -> accepted normally.
- CHECK_ETYPE = 1 with EtherType 0x0806 to MAC_ADDR -> dropped. With EtherType 0x0800 -> accepted.
- Runt frame of 30 dibits -> no pulse, no output. Following valid frame -> accepted, counter clearly restarted at 0.
- Assert rst low mid-payload -> axiov = 0 immediately (async). After release, mid-frame remainder treated as new header (no spurious output). Next clean frame accepted.
